// File: rtl/ghost_limit_scanner.sv
// Per-frame neighbour scan: turns a ghost pixel position into a tile and four open-path flags.
// Outputs publish 6 edges after scan_start is sampled; no backpressure, starts during a scan are dropped.
module ghost_limit_scanner #(
  parameter int H_BOARD_ON = 200,
  parameter int V_BOARD_ON = 40,
  parameter int TILE_SHIFT = 4,
  parameter int CENTER_OFF = 8,
  parameter int MAZE_W     = 28,
  parameter int MAZE_H     = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_start,
  input  logic [10:0] h_ghost_pos,
  input  logic [9:0]  v_ghost_pos,
  input  logic        door_pass,
  output logic [9:0]  maze_addr,
  input  logic [1:0]  maze_data,
  output logic [4:0]  h_tile,
  output logic [4:0]  v_tile,
  output logic        up_limit,
  output logic        down_limit,
  output logic        left_limit,
  output logic        right_limit,
  output logic        scan_busy,
  output logic        scan_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_RD_U, S_RD_D, S_RD_L, S_RD_R, S_LAST, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [10:0] h_pos_q;
  logic [9:0]  v_pos_q;
  logic [1:0]  up_dat, dn_dat, lt_dat;

  logic [10:0] h_rel, ht_raw;
  logic [9:0]  v_rel, vt_raw;
  logic        h_off, h_hi, v_off, v_hi, off_board;
  logic        h_al, v_al;
  logic [4:0]  ht, vt;
  logic [4:0]  rd_row, rd_col;
  logic        up_nxt, dn_nxt, lt_nxt, rt_nxt;

  function automatic logic is_open(input logic [1:0] d, input logic door);
    case (d)
      2'd1:    is_open = 1'b0;
      2'd2:    is_open = door;
      default: is_open = 1'b1;
    endcase
  endfunction

  // Tile geometry from the positions latched at the end of CALC
  always_comb begin
    h_rel     = h_pos_q - 11'(H_BOARD_ON);
    v_rel     = v_pos_q - 10'(V_BOARD_ON);
    ht_raw    = h_rel >> TILE_SHIFT;
    vt_raw    = v_rel >> TILE_SHIFT;
    h_off     = (h_pos_q < 11'(H_BOARD_ON));
    v_off     = (v_pos_q < 10'(V_BOARD_ON));
    h_hi      = !h_off && (ht_raw >= 11'(MAZE_W));
    v_hi      = !v_off && (vt_raw >= 10'(MAZE_H));
    off_board = h_off | h_hi | v_off | v_hi;
    h_al      = (h_rel[TILE_SHIFT-1:0] == TILE_SHIFT'(CENTER_OFF));
    v_al      = (v_rel[TILE_SHIFT-1:0] == TILE_SHIFT'(CENTER_OFF));
    ht        = h_off ? 5'd0 : (h_hi ? 5'(MAZE_W - 1) : ht_raw[4:0]);
    vt        = v_off ? 5'd0 : (v_hi ? 5'(MAZE_H - 1) : vt_raw[4:0]);
  end

  // Edge rows wrap inside the ROM; the gating below discards that data
  always_comb begin
    rd_row    = vt;
    rd_col    = ht;
    maze_addr = 10'd0;
    case (state)
      S_RD_U: rd_row = (vt == 5'd0) ? 5'(MAZE_H - 1) : vt - 5'd1;
      S_RD_D: rd_row = (vt == 5'(MAZE_H - 1)) ? 5'd0 : vt + 5'd1;
      S_RD_L: rd_col = (ht == 5'd0) ? 5'(MAZE_W - 1) : ht - 5'd1;
      S_RD_R: rd_col = (ht == 5'(MAZE_W - 1)) ? 5'd0 : ht + 5'd1;
      default: ;
    endcase
    if (state inside {S_RD_U, S_RD_D, S_RD_L, S_RD_R})
      maze_addr = 10'(rd_row) * 10'(MAZE_W) + 10'(rd_col);
  end

  // Right neighbour data arrives during LAST and is used directly at publish
  always_comb begin
    up_nxt = 1'b0;
    dn_nxt = 1'b0;
    lt_nxt = 1'b1;
    rt_nxt = 1'b1;
    if (!off_board) begin
      up_nxt = h_al && (vt != 5'd0)             && is_open(up_dat, door_pass);
      dn_nxt = h_al && (vt != 5'(MAZE_H - 1))   && is_open(dn_dat, door_pass);
      lt_nxt = v_al && is_open(lt_dat, door_pass);
      rt_nxt = v_al && is_open(maze_data, door_pass);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (scan_start) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_RD_U;
      S_RD_U:  state_nxt = S_RD_D;
      S_RD_D:  state_nxt = S_RD_L;
      S_RD_L:  state_nxt = S_RD_R;
      S_RD_R:  state_nxt = S_LAST;
      S_LAST:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign scan_busy = (state != S_IDLE);
  assign scan_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      h_pos_q     <= '0;
      v_pos_q     <= '0;
      up_dat      <= '0;
      dn_dat      <= '0;
      lt_dat      <= '0;
      h_tile      <= '0;
      v_tile      <= '0;
      up_limit    <= 1'b0;
      down_limit  <= 1'b0;
      left_limit  <= 1'b0;
      right_limit <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_CALC: begin
          h_pos_q <= h_ghost_pos;
          v_pos_q <= v_ghost_pos;
        end
        S_RD_D: up_dat <= maze_data;
        S_RD_L: dn_dat <= maze_data;
        S_RD_R: lt_dat <= maze_data;
        S_LAST: begin
          h_tile      <= ht;
          v_tile      <= vt;
          up_limit    <= up_nxt;
          down_limit  <= dn_nxt;
          left_limit  <= lt_nxt;
          right_limit <= rt_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_limit_scanner.sv
// Scoreboard bench for ghost_limit_scanner with a registered maze ROM model.
module tb_ghost_limit_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_start = 1'b0;
  logic [10:0] h_ghost_pos = '0;
  logic [9:0]  v_ghost_pos = '0;
  logic        door_pass = 1'b0;
  logic [9:0]  maze_addr;
  logic [1:0]  maze_data = '0;
  logic [4:0]  h_tile, v_tile;
  logic        up_limit, down_limit, left_limit, right_limit;
  logic        scan_busy, scan_done;

  ghost_limit_scanner dut (
    .clk(clk), .reset(reset), .scan_start(scan_start),
    .h_ghost_pos(h_ghost_pos), .v_ghost_pos(v_ghost_pos), .door_pass(door_pass),
    .maze_addr(maze_addr), .maze_data(maze_data),
    .h_tile(h_tile), .v_tile(v_tile),
    .up_limit(up_limit), .down_limit(down_limit),
    .left_limit(left_limit), .right_limit(right_limit),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  logic [1:0] rom [0:1023];
  always @(posedge clk) maze_data <= rom[maze_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  typedef struct {
    int ht; int vt; int u; int d; int l; int r; int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tile_open(input int a, input bit door);
    return (rom[a] == 2'd0 || rom[a] == 2'd3 || (rom[a] == 2'd2 && door)) ? 1 : 0;
  endfunction

  function automatic exp_t model(input int h, input int v, input bit door);
    exp_t e;
    int hr, vr, ht, vt;
    bit off, hal, val;
    hr = h - 200;
    vr = v - 40;
    ht = (hr < 0) ? 0 : ((hr / 16 > 27) ? 27 : hr / 16);
    vt = (vr < 0) ? 0 : ((vr / 16 > 30) ? 30 : vr / 16);
    off = (hr < 0) || (vr < 0) || (hr / 16 >= 28) || (vr / 16 >= 31);
    hal = (hr % 16) == 8;
    val = (vr % 16) == 8;
    e.ht = ht;
    e.vt = vt;
    if (off) begin
      e.u = 0; e.d = 0; e.l = 1; e.r = 1;
    end else begin
      e.u = (hal && vt != 0)  ? tile_open((vt - 1) * 28 + ht, door) : 0;
      e.d = (hal && vt != 30) ? tile_open((vt + 1) * 28 + ht, door) : 0;
      e.l = val ? tile_open(vt * 28 + (ht == 0 ? 27 : ht - 1), door) : 0;
      e.r = val ? tile_open(vt * 28 + (ht == 27 ? 0 : ht + 1), door) : 0;
    end
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && scan_done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.cyc);
        check_val("h_tile", int'(h_tile), e.ht);
        check_val("v_tile", int'(v_tile), e.vt);
        check_val("up_limit", int'(up_limit), e.u);
        check_val("down_limit", int'(down_limit), e.d);
        check_val("left_limit", int'(left_limit), e.l);
        check_val("right_limit", int'(right_limit), e.r);
      end
    end
  end

  // Returns at the negedge after the edge that samples scan_start
  task automatic start_scan(input int h, input int v, input bit door, input bit expect_scan);
    exp_t e;
    @(negedge clk);
    h_ghost_pos = 11'(h);
    v_ghost_pos = 10'(v);
    door_pass   = door;
    scan_start  = 1'b1;
    if (expect_scan) begin
      e = model(h, v, door);
      e.cyc = cyc + 7;
      sb.push_back(e);
    end
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_addr"}, int'(maze_addr), 0);
    check_val({tag, "_tiles"}, int'({h_tile, v_tile}), 0);
    check_val({tag, "_limits"}, int'({up_limit, down_limit, left_limit, right_limit}), 0);
    check_val({tag, "_flags"}, int'({scan_busy, scan_done}), 0);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 1024; i++) rom[i] = 2'd0;

    // Reset with scan_start held high must not launch a scan
    scan_start = 1'b1;
    h_ghost_pos = 11'd288;
    v_ghost_pos = 10'd96;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    scan_start = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs_zero("idle");
    check_val("idle_no_done", done_count, 0);

    // Centre tile (5,3): U wall, D empty, L pellet, R door
    rom[2 * 28 + 5] = 2'd1;
    rom[4 * 28 + 5] = 2'd0;
    rom[3 * 28 + 4] = 2'd3;
    rom[3 * 28 + 6] = 2'd2;
    start_scan(288, 96, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    start_scan(288, 96, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    // Tunnel at ht=0, vt=14
    start_scan(208, 272, 1'b0, 1'b1);
    @(negedge clk); check_val("addr_up", int'(maze_addr), 13 * 28);
    @(negedge clk); check_val("addr_down", int'(maze_addr), 15 * 28);
    @(negedge clk); check_val("addr_left", int'(maze_addr), 419);
    @(negedge clk); check_val("addr_right", int'(maze_addr), 393);
    repeat (6) @(negedge clk);
    check_val("addr_idle", int'(maze_addr), 0);

    // Misaligned horizontally: up/down gated off
    rom[2 * 28 + 5] = 2'd0;
    rom[3 * 28 + 4] = 2'd0;
    rom[3 * 28 + 6] = 2'd0;
    start_scan(283, 96, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Top row: up forced closed although the wrapped ROM read is empty
    start_scan(288, 48, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Off board on both sides
    start_scan(100, 96, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    start_scan(200 + 30 * 16 + 8, 600, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Second start during a scan is dropped
    dc = done_count;
    start_scan(288, 96, 1'b1, 1'b1);
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (12) @(negedge clk);
    check_val("single_done", done_count - dc, 1);

    // Reset mid-scan discards the scan and clears outputs
    dc = done_count;
    start_scan(288, 96, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midscan_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("reset_no_done", done_count - dc, 0);

    check_val("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
